// File: rtl/serial_adder_if.sv
// serial_adder_if: start/done handshake and operand/result bus for serial_adder
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic             cout;
  logic             ovf;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
  modport slave (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract, LSB first; subtract enabled by SERIAL_ADDER_SUB_EN
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             sub_eff, s_bit, c_bit;
`ifdef SERIAL_ADDER_SUB_EN
  assign sub_eff = bus.sub;
`else
  logic sub_unused;
  assign sub_unused = bus.sub;
  assign sub_eff = 1'b0;
`endif
  assign s_bit = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_bit = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign bus.busy = state_q == RUN;
  assign bus.done = state_q == DONE;
  assign bus.sum = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf = ovf_q;
  // next state: load operands on accepted start, process one bit per cycle in RUN;
  // on the last bit carry_q is the carry into the MSB, so ovf is it XOR the carry out
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    sum_d = sum_q;
    cnt_d = cnt_q;
    carry_d = carry_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    if (state_q == RUN) begin
      a_d = a_q >> 1;
      b_d = b_q >> 1;
      res_d = {s_bit, res_q[WIDTH-1:1]};
      carry_d = c_bit;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = DONE;
        sum_d = res_d;
        cout_d = c_bit;
        ovf_d = c_bit ^ carry_q;
      end
    end else if (bus.start) begin
      state_d = RUN;
      a_d = bus.a;
      b_d = bus.b ^ {WIDTH{sub_eff}};
      carry_d = bus.cin ^ sub_eff;
      cnt_d = '0;
    end else begin
      state_d = IDLE;
    end
  end
  // state register with synchronous reset clearing datapath and results
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      sum_q <= '0;
      cnt_q <= '0;
      carry_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      carry_q <= carry_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
    end
  end
endmodule
